// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, control states
// and instruction field positions.
package cpu_pkg;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  typedef enum logic [3:0] {
    OP_INC  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_DEC  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_INV  = 4'h7,
    OP_SHR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_MOV  = 4'hA,
    OP_NAND = 4'hB,
    OP_LDA  = 4'hC,
    OP_STA  = 4'hD,
    OP_JMP  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_NAND;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: result = a op b, with carry/borrow out for ADD/SUB.
module alu
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o,
  output logic       e_o
);

  logic [8:0] wide;

  always_comb begin
    wide = 9'd0;
    y_o  = a_i;
    e_o  = 1'b0;
    case (op_i)
      OP_INC:  y_o = a_i + 8'd1;
      OP_ADD: begin
        wide = {1'b0, a_i} + {1'b0, b_i};
        y_o  = wide[7:0];
        e_o  = wide[8];
      end
      OP_SUB: begin
        // bit 8 of the 9-bit difference is the borrow (a < b)
        wide = {1'b0, a_i} - {1'b0, b_i};
        y_o  = wide[7:0];
        e_o  = wide[8];
      end
      OP_DEC:  y_o = a_i - 8'd1;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_INV:  y_o = ~a_i;
      OP_SHR:  y_o = {1'b0, a_i[7:1]};
      OP_SHL:  y_o = {a_i[6:0], 1'b0};
      OP_MOV:  y_o = a_i;
      OP_NAND: y_o = ~(a_i & b_i);
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC sequencer with PC, IR, AC and E
// registers, issuing operands to an external combinational ALU.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  output logic        dmem_we,
  input  logic [7:0]  dmem_rdata,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_e,
  input  logic [7:0]  alu_out,
  input  logic        alu_e_out,
  output logic [7:0]  ac,
  output logic        e_flag,
  output logic        busy,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  ac_q, ac_d;
  logic        e_q, e_d;
  opcode_e     op;
  logic        unused_ir;

  assign op        = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign unused_ir = ^ir_q[11:8];  // reserved instruction field

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      ac_q    <= 8'h00;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      e_q     <= e_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    ac_d      = ac_q;
    e_d       = e_q;
    dmem_we   = 1'b0;
    dmem_addr = ir_q[ADDR_MSB:ADDR_LSB];
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (run) begin
          pc_d    = RESET_PC;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        // address the operand now so the synchronous RAM delivers it in EXEC
        ir_d      = imem_data;
        pc_d      = pc_q + 8'd1;
        dmem_addr = imem_data[ADDR_MSB:ADDR_LSB];
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_alu_op(op)) begin
          ac_d = alu_out;
          if (op == OP_ADD || op == OP_SUB) e_d = alu_e_out;
        end else begin
          case (op)
            OP_LDA:  ac_d = dmem_rdata;
            OP_STA:  dmem_we = 1'b1;
            OP_JMP:  pc_d = ir_q[ADDR_MSB:ADDR_LSB];
            OP_HLT:  state_d = ST_HALT;
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr  = pc_q;
  assign dmem_wdata = ac_q;
  assign alu_op     = ir_q[OP_MSB:OP_LSB];
  assign alu_a      = ac_q;
  assign alu_b      = dmem_rdata;
  assign alu_e      = e_q;
  assign ac         = ac_q;
  assign e_flag     = e_q;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
  assign halted     = (state_q == ST_HALT);

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multi-cycle control unit for the 8-bit accumulator CPU; the issuing side of the ALU interface.
- Fetches 16-bit instructions and reads operands from data memory.
- Drives the ALU opcode and operands, then writes the ALU result and E flag back into AC/E.
- Also executes the non-ALU instructions: LDA, STA, JMP, HLT.

Parameters:
- RESET_PC, 8'h00, PC value loaded at reset and on every restart from IDLE/HALT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  start pulse; sampled in IDLE and HALT only.
- imem_addr  output  8  instruction address; equals PC.
- imem_data  input  16  instruction word; synchronous ROM, valid 1 cycle after address.
- dmem_addr  output  8  data address; imem_data[7:0] in DECODE, IR[7:0] otherwise.
- dmem_wdata  output  8  equals AC.
- dmem_we  output  1  data write strobe.
- dmem_rdata  input  8  data read; synchronous RAM, valid 1 cycle after address.
- alu_op  output  4  equals IR[15:12].
- alu_a  output  8  equals AC.
- alu_b  output  8  equals dmem_rdata.
- alu_e  output  1  equals E register.
- alu_out  input  8  ALU result.
- alu_e_out  input  1  ALU carry/borrow out.
- ac  output  8  accumulator (debug/visible).
- e_flag  output  1  E register.
- busy  output  1  high in FETCH/DECODE/EXEC.
- halted  output  1  high in HALT.

Behaviour:
- Instruction format:
  - [15:12] op; [11:8] ignored; [7:0] address.
  - op 0x0-0xB: ALU ops. INC, ADD, SUB, DEC, AND, OR, XOR, INV, SHR, SHL, MOV, NAND. Computed as AC op mem[addr].
  - op 0xC: LDA, AC <= mem[addr].
  - op 0xD: STA, mem[addr] <= AC.
  - op 0xE: JMP, PC <= addr.
  - op 0xF: HLT.
- Reset values:
  - Registers: state IDLE, PC=RESET_PC, IR=16'h0000, AC=0, E=0.
  - Outputs: dmem_we=0, busy=0, halted=0.
- States:
  - IDLE: wait for run=1, then PC<=RESET_PC and go to FETCH.
  - FETCH: imem_addr=PC; go to DECODE.
  - DECODE: IR<=imem_data; PC<=PC+1 (8-bit wrap, 8'hFF -> 8'h00). dmem_addr=imem_data[7:0] so the operand is valid in EXEC. Go to EXEC.
  - EXEC, by op:
    - 0x0-0xB: AC<=alu_out.
    - 0x1, 0x2: also E<=alu_e_out. All other ALU ops leave E unchanged.
    - 0xC: AC<=dmem_rdata.
    - 0xD: dmem_we=1 for exactly this cycle.
    - 0xE: PC<=IR[7:0]; this overrides the increment done in DECODE.
    - 0xF: go to HALT.
    - Every other op then returns to FETCH.
  - HALT: halted=1; hold all registers. run=1 -> PC<=RESET_PC and go to FETCH; AC/E are kept.
- Timing and handshake:
  - Fixed 3 cycles per instruction; no stalls.
  - The ALU is purely combinational; its result is consumed in the same EXEC cycle.
  - Unary ops (INC, DEC, INV, SHR, SHL, MOV) ignore alu_b, but the operand read still occurs and is harmless.
- dmem_we is asserted only in EXEC with op 0xD, never in any other state.
- run is ignored while busy.
- Reset mid-instruction, including during an STA EXEC cycle: the next cycle is IDLE with dmem_we=0 and all reset values restored.
- Reset has priority over run when both are asserted.

Decomposition:
- Shared package cpu_pkg:
  - 4-bit opcode constants OP_INC..OP_NAND, OP_LDA, OP_STA, OP_JMP, OP_HLT.
  - State encoding ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT.
  - Field positions OP_MSB/OP_LSB and ADDR_MSB/ADDR_LSB.
- The existing alu module stays external and is instantiated beside cpu_control at top level; the bench instantiates it too.
- No sub-module inside cpu_control; the FSM and datapath registers live in one block.

Test Plan:
- Reset/run sequencing: assert reset 2 cycles, then pulse run. Required:
  - busy=0 and halted=0 during reset.
  - imem_addr=8'h00 in the first FETCH.
  - PC=8'h01 after the first DECODE.
- LDA/ADD carry: mem[10]=8'hF0, mem[11]=8'h20; program LDA 10, ADD 11, STA 12, HLT. Required:
  - mem[12]=8'h10 and e_flag=1.
  - halted=1 exactly 12 cycles after the first FETCH.
- SUB/E and unary ops: AC=8'h05 via LDA, then SUB of 8'h07, SHL, INV. Required:
  - After SUB: AC=8'hFE, E=1.
  - After SHL: AC=8'hFC.
  - After INV: AC=8'h03, E still 1.
- JMP/PC wrap:
  - Program JMP 8'hFE, where mem FE holds INC and FF holds JMP 8'h00. PC sequences FE, FF, 00 and AC increments once per loop.
  - Separately, a non-jump instruction at 8'hFF -> PC wraps to 8'h00.
- Reset during STA: assert reset in the STA EXEC cycle. Required:
  - The next cycle has dmem_we=0, state IDLE, AC=0.
  - The memory word holds whatever value the write strobe left; no second write occurs.
- Run while busy / restart from HALT:
  - A run pulse mid-program is ignored; the instruction trace is unchanged.
  - A run pulse in HALT refetches from 8'h00 with AC preserved.
